// File: rtl/fighter_state_ctrl.sv
// Per-player move/attack sequencer: turns buttons and hit events into fighter state
// and sprite x position, advancing once per frame tick.
module fighter_state_ctrl #(
  parameter int unsigned X_INIT          = 100,
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = 576,
  parameter int unsigned STEP_PX         = 2,
  parameter int unsigned STARTUP_FRAMES  = 5,
  parameter int unsigned ACTIVE_FRAMES   = 3,
  parameter int unsigned RECOVERY_FRAMES = 8,
  parameter int unsigned HITSTUN_FRAMES  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_back,
  input  logic       btn_fwd,
  input  logic       btn_attack,
  input  logic       got_hit,
  output logic [2:0] state,
  output logic [9:0] sprite_x,
  output logic [3:0] frames_left,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_BACKWARD     = 3'd1,
    ST_FORWARD      = 3'd2,
    ST_ATK_START    = 3'd3,
    ST_ATK_ACTIVE   = 3'd4,
    ST_ATK_RECOVERY = 3'd5,
    ST_HITSTUN      = 3'd6
  } state_e;

  localparam logic [9:0]  X_INIT_P   = 10'(X_INIT);
  localparam logic [10:0] X_MIN_W    = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
  localparam logic [10:0] STEP_W     = 11'(STEP_PX);
  localparam logic [3:0]  START_LOAD = 4'(STARTUP_FRAMES - 1);
  localparam logic [3:0]  ACT_LOAD   = 4'(ACTIVE_FRAMES - 1);
  localparam logic [3:0]  REC_LOAD   = 4'(RECOVERY_FRAMES - 1);
  localparam logic [3:0]  HIT_LOAD   = 4'(HITSTUN_FRAMES - 1);

  state_e      state_q, state_d;
  logic [9:0]  sprite_x_q, sprite_x_d;
  logic [3:0]  frames_left_q, frames_left_d;
  logic        atk_pending_q, atk_pending_d;
  logic        btn_attack_q, btn_attack_d;

  logic        atk_rise;
  logic        atk_req;
  logic [10:0] x_ext;
  logic [10:0] x_inc;
  logic [10:0] x_dec;
  logic [9:0]  x_fwd;
  logic [9:0]  x_back;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sprite_x_q    <= X_INIT_P;
      frames_left_q <= '0;
      atk_pending_q <= 1'b0;
      btn_attack_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sprite_x_q    <= sprite_x_d;
      frames_left_q <= frames_left_d;
      atk_pending_q <= atk_pending_d;
      btn_attack_q  <= btn_attack_d;
    end
  end

  // Clamped walk targets; 11-bit math keeps both directions from wrapping.
  always_comb begin
    x_ext  = {1'b0, sprite_x_q};
    x_inc  = x_ext + STEP_W;
    x_dec  = x_ext - STEP_W;
    x_fwd  = (x_inc > X_MAX_W) ? X_MAX_W[9:0] : x_inc[9:0];
    x_back = (x_ext < (X_MIN_W + STEP_W)) ? X_MIN_W[9:0] : x_dec[9:0];
  end

  always_comb begin
    btn_attack_d  = btn_attack;
    atk_rise      = btn_attack & ~btn_attack_q;
    atk_req       = atk_pending_q | atk_rise;
    // Requests never outlive a tick, whether consumed or discarded.
    atk_pending_d = frame_tick ? 1'b0 : atk_req;

    state_d       = state_q;
    sprite_x_d    = sprite_x_q;
    frames_left_d = frames_left_q;

    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_BACKWARD, ST_FORWARD: begin
          frames_left_d = '0;
          if (got_hit) begin
            state_d       = ST_HITSTUN;
            frames_left_d = HIT_LOAD;
          end else if (atk_req) begin
            state_d       = ST_ATK_START;
            frames_left_d = START_LOAD;
          end else if (btn_fwd && !btn_back) begin
            state_d    = ST_FORWARD;
            sprite_x_d = x_fwd;
          end else if (btn_back && !btn_fwd) begin
            state_d    = ST_BACKWARD;
            sprite_x_d = x_back;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ATK_START, ST_ATK_ACTIVE, ST_ATK_RECOVERY: begin
          if (got_hit) begin
            state_d       = ST_HITSTUN;
            frames_left_d = HIT_LOAD;
          end else if (frames_left_q != '0) begin
            frames_left_d = frames_left_q - 4'd1;
          end else if (state_q == ST_ATK_START) begin
            state_d       = ST_ATK_ACTIVE;
            frames_left_d = ACT_LOAD;
          end else if (state_q == ST_ATK_ACTIVE) begin
            state_d       = ST_ATK_RECOVERY;
            frames_left_d = REC_LOAD;
          end else begin
            state_d       = ST_IDLE;
            frames_left_d = '0;
          end
        end
        ST_HITSTUN: begin
          if (frames_left_q != '0) begin
            frames_left_d = frames_left_q - 4'd1;
          end else begin
            state_d       = ST_IDLE;
            frames_left_d = '0;
          end
        end
        default: begin
          state_d       = ST_IDLE;
          frames_left_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_ATK_START, ST_ATK_ACTIVE, ST_ATK_RECOVERY, ST_HITSTUN: busy = 1'b1;
      default:                                                 busy = 1'b0;
    endcase
  end

  assign state       = state_q;
  assign sprite_x    = sprite_x_q;
  assign frames_left = frames_left_q;

endmodule

// File: tb/tb_fighter_state_ctrl.sv
// Directed bench for fighter_state_ctrl: a frame-level behavioural model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_fighter_state_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, btn_back, btn_fwd, btn_attack, got_hit;
  logic [2:0] state,  state2;
  logic [9:0] sprite_x, sprite_x2;
  logic [3:0] frames_left, frames_left2;
  logic       busy, busy2;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  fighter_state_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_back(btn_back),
    .btn_fwd(btn_fwd), .btn_attack(btn_attack), .got_hit(got_hit),
    .state(state), .sprite_x(sprite_x), .frames_left(frames_left), .busy(busy)
  );

  // Second instance starting at an odd x so both clamp limits are reached exactly.
  fighter_state_ctrl #(.X_INIT(575)) dut2 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_back(btn_back),
    .btn_fwd(btn_fwd), .btn_attack(btn_attack), .got_hit(got_hit),
    .state(state2), .sprite_x(sprite_x2), .frames_left(frames_left2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_rem counts whole ticks left in a timed state; frames_left is m_rem-1.
  int m_state, m_x, m_rem;
  bit m_pend, m_prev;

  function automatic int dur_of(input int s);
    case (s)
      3: return 5;
      4: return 3;
      5: return 8;
      6: return 12;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    bit rise, req;
    if (rst) begin
      m_state = 0; m_x = 100; m_rem = 0; m_pend = 0; m_prev = 0;
    end else begin
      rise = btn_attack && !m_prev;
      req  = m_pend || rise;
      if (frame_tick) begin
        if (m_state <= 2) begin
          if (got_hit)                 begin m_state = 6; m_rem = dur_of(6); end
          else if (req)                begin m_state = 3; m_rem = dur_of(3); end
          else if (btn_fwd && !btn_back) begin
            m_state = 2; m_x = (m_x + 2 > 576) ? 576 : m_x + 2;
          end else if (btn_back && !btn_fwd) begin
            m_state = 1; m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
          end else m_state = 0;
        end else if (got_hit && m_state != 6) begin
          m_state = 6; m_rem = dur_of(6);
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_state = (m_state == 3) ? 4 : (m_state == 4) ? 5 : 0;
            m_rem   = dur_of(m_state);
          end
        end
        m_pend = 0;
      end else begin
        m_pend = req;
      end
      m_prev = btn_attack;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state", int'(state), m_state);
      check("sprite_x", int'(sprite_x), m_x);
      check("frames_left", int'(frames_left), (m_state >= 3) ? m_rem - 1 : 0);
      check("busy", int'(busy), (m_state >= 3) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 0; btn_back = 0; btn_fwd = 0; btn_attack = 0; got_hit = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    check("rst_state", int'(state), 0);
    check("rst_x", int'(sprite_x), 100);
    check("rst_fl", int'(frames_left), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_x2", int'(sprite_x2), 575);

    // Walk forward three frames, then both buttons
    btn_fwd = 1;
    tick();
    check("clamp_hi_x2", int'(sprite_x2), 576);
    tick(); tick();
    check("walk_state", int'(state), 2);
    check("walk_x", int'(sprite_x), 106);
    check("clamp_hi_hold_x2", int'(sprite_x2), 576);
    btn_back = 1;
    tick();
    check("both_state", int'(state), 0);
    check("both_x", int'(sprite_x), 106);
    btn_back = 0; btn_fwd = 0;

    // Asynchronous reset asserted mid-cycle, checked before any clock edge
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_x", int'(sprite_x), 100);
    check("arst_fl", int'(frames_left), 0);
    check("arst_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Walk back to the left limit
    btn_back = 1;
    repeat (287) tick();
    check("back_x2", int'(sprite_x2), 1);
    check("back_state2", int'(state2), 1);
    tick();
    check("clamp_lo_x2", int'(sprite_x2), 0);
    tick();
    check("clamp_lo_hold_x2", int'(sprite_x2), 0);
    check("clamp_lo_x", int'(sprite_x), 0);
    btn_back = 0;

    // Full attack sequence with the button held throughout
    do_reset();
    btn_attack = 1;
    tick();
    check("atk_start", int'(state), 3);
    check("atk_start_fl", int'(frames_left), 4);
    check("atk_busy", int'(busy), 1);
    repeat (4) tick();
    check("atk_start_last", int'(state), 3);
    tick();
    check("atk_active", int'(state), 4);
    check("atk_active_fl", int'(frames_left), 2);
    repeat (3) tick();
    check("atk_recovery", int'(state), 5);
    check("atk_recovery_fl", int'(frames_left), 7);
    btn_attack = 0;
    tick();
    btn_attack = 1;
    tick();
    repeat (5) tick();
    check("rec_last", int'(state), 5);
    check("rec_last_fl", int'(frames_left), 0);
    tick();
    check("atk_done", int'(state), 0);
    check("atk_x", int'(sprite_x), 100);
    tick();
    check("no_retrigger", int'(state), 0);

    // Hit during the active window, got_hit held high
    btn_attack = 0;
    tick();
    btn_attack = 1;
    tick();
    repeat (5) tick();
    check("hit_active", int'(state), 4);
    tick();
    got_hit = 1;
    tick();
    check("hitstun", int'(state), 6);
    check("hitstun_fl", int'(frames_left), 11);
    btn_attack = 0;
    repeat (11) tick();
    check("hitstun_last", int'(state), 6);
    check("hitstun_last_fl", int'(frames_left), 0);
    tick();
    check("hitstun_exit", int'(state), 0);

    // Hit and attack edge on the same tick in IDLE
    @(posedge clk); #1 frame_tick = 1'b1; btn_attack = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    check("hit_wins", int'(state), 6);
    check("hit_wins_fl", int'(frames_left), 11);
    got_hit = 0; btn_attack = 0;
    repeat (12) tick();
    check("final_idle", int'(state), 0);
    check("final_busy", int'(busy), 0);

    repeat (2) @(posedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule
